// File: rtl/aes_ahb_master.sv
// AHB-Lite master that walks the AES slave register sequence for one key/plaintext job:
// configure, load key and plaintext, start, poll for done, then read back the ciphertext.
module aes_ahb_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          POLL_MAX  = 1024,
    parameter int          RDATA_LAT = 0
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_key,
    input  logic [127:0] req_pt,
    input  logic         req_bist,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_ct,
    output logic         rsp_err,
    output logic         busy,
    output logic [31:0]  HADDR,
    output logic [1:0]   HTRANS,
    output logic         HWRITE,
    output logic [2:0]   HSIZE,
    output logic [2:0]   HBURST,
    output logic [31:0]  HWDATA,
    input  logic [31:0]  HRDATA,
    input  logic         HREADY,
    input  logic         HRESP,
    output logic [2:0]   dbg_state
);
    // Handshakes: a transfer on req_* or rsp_* happens on a rising HCLK edge where valid and
    // ready are both high; valid never drops and payload never changes while waiting for ready.

    localparam int         PW         = $clog2(POLL_MAX + 1);
    localparam logic [1:0] HT_IDLE    = 2'b00;
    localparam logic [1:0] HT_NONSEQ  = 2'b10;
    localparam logic [3:0] STEP_START = 4'd9;
    localparam logic [3:0] STEP_POLL  = 4'd10;
    localparam logic [3:0] STEP_CT0   = 4'd11;
    localparam logic [3:0] STEP_LAST  = 4'd14;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_RCAP = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    function automatic logic [7:0] step_offset(input logic [3:0] s);
        case (s)
            4'd0:    step_offset = 8'h04;
            4'd1:    step_offset = 8'h10;
            4'd2:    step_offset = 8'h14;
            4'd3:    step_offset = 8'h18;
            4'd4:    step_offset = 8'h1C;
            4'd5:    step_offset = 8'h20;
            4'd6:    step_offset = 8'h24;
            4'd7:    step_offset = 8'h28;
            4'd8:    step_offset = 8'h2C;
            4'd9:    step_offset = 8'h00;
            4'd10:   step_offset = 8'h08;
            4'd11:   step_offset = 8'h30;
            4'd12:   step_offset = 8'h34;
            4'd13:   step_offset = 8'h38;
            4'd14:   step_offset = 8'h3C;
            default: step_offset = 8'h00;
        endcase
    endfunction

    // Steps 1..4 and 5..8 both map their low two bits minus one onto word 0..3.
    function automatic logic [31:0] step_wdata(input logic [3:0] s, input logic [127:0] key,
                                               input logic [127:0] pt, input logic bist);
        logic [1:0] w;
        w = s[1:0] - 2'd1;
        if (s == 4'd0)      step_wdata = {31'b0, bist};
        else if (s <= 4'd4) step_wdata = key[{w, 5'b0} +: 32];
        else if (s <= 4'd8) step_wdata = pt[{w, 5'b0} +: 32];
        else                step_wdata = 32'h1;
    endfunction

    state_e         state_q, state_d;
    logic [3:0]     step_q, step_d;
    logic [PW-1:0]  poll_q, poll_d;
    logic [127:0]   key_q, key_d, pt_q, pt_d;
    logic           bist_q, bist_d;
    logic [31:0]    haddr_q, haddr_d, hwdata_q, hwdata_d;
    logic [1:0]     htrans_q, htrans_d;
    logic           hwrite_q, hwrite_d;
    logic           rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [127:0]   rsp_ct_q, rsp_ct_d;

    logic           issue, abort, rd_done;
    logic [3:0]     issue_step;
    logic [PW-1:0]  poll_inc;
    logic [1:0]     ct_idx;

    assign poll_inc = poll_q + PW'(1);
    assign ct_idx   = step_q[1:0] + 2'd1;

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        poll_d      = poll_q;
        key_d       = key_q;
        pt_d        = pt_q;
        bist_d      = bist_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_ct_d    = rsp_ct_q;
        issue       = 1'b0;
        issue_step  = step_q;
        abort       = 1'b0;
        rd_done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    key_d      = req_key;
                    pt_d       = req_pt;
                    bist_d     = req_bist;
                    poll_d     = '0;
                    rsp_ct_d   = '0;
                    rsp_err_d  = 1'b0;
                    issue      = 1'b1;
                    issue_step = 4'd0;
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    state_d  = ST_DATA;
                    htrans_d = HT_IDLE;
                    if (hwrite_q) hwdata_d = step_wdata(step_q, key_q, pt_q, bist_q);
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    if (HRESP) begin
                        abort = 1'b1;
                    end else if (hwrite_q) begin
                        issue      = 1'b1;
                        issue_step = step_q + 4'd1;
                    end else if (RDATA_LAT != 0) begin
                        state_d = ST_RCAP;
                    end else begin
                        rd_done = 1'b1;
                    end
                end
            end
            ST_RCAP: rd_done = 1'b1;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // STAT0 bit0 is the done flag; CT3 is read last since that read clears it in the slave.
        if (rd_done) begin
            if (step_q == STEP_POLL) begin
                if (HRDATA[0]) begin
                    issue      = 1'b1;
                    issue_step = STEP_CT0;
                end else if (poll_inc == PW'(POLL_MAX)) begin
                    abort = 1'b1;
                end else begin
                    poll_d     = poll_inc;
                    issue      = 1'b1;
                    issue_step = STEP_POLL;
                end
            end else begin
                rsp_ct_d[{ct_idx, 5'b0} +: 32] = HRDATA;
                if (step_q == STEP_LAST) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    issue      = 1'b1;
                    issue_step = step_q + 4'd1;
                end
            end
        end

        if (issue) begin
            state_d  = ST_ADDR;
            step_d   = issue_step;
            htrans_d = HT_NONSEQ;
            haddr_d  = BASE_ADDR + {24'b0, step_offset(issue_step)};
            hwrite_d = (issue_step <= STEP_START);
        end

        if (abort) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_ct_d    = '0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            poll_q      <= '0;
            key_q       <= '0;
            pt_q        <= '0;
            bist_q      <= 1'b0;
            haddr_q     <= '0;
            htrans_q    <= HT_IDLE;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_ct_q    <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            poll_q      <= poll_d;
            key_q       <= key_d;
            pt_q        <= pt_d;
            bist_q      <= bist_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_ct_q    <= rsp_ct_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_ct    = rsp_ct_q;
    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HWDATA    = hwdata_q;
    assign HSIZE     = 3'b010;
    assign HBURST    = 3'b000;
    assign dbg_state = state_q;

endmodule
